// File: rtl/sqrt_sched.sv
// Round-robin front end that shares one square-root engine between four requesters.
// One engine operation is in flight at a time; a response is held until the consumer accepts it.
module sqrt_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_operand,
    output logic [NREQ-1:0]      gnt,
    output logic                 eng_start,
    output logic [7:0]           eng_operand,
    input  logic                 eng_done,
    input  logic [3:0]           eng_root,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [1:0]           resp_id,
    output logic [3:0]           resp_root,
    output logic                 resp_err,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    // Handshakes: a grant pulse is the capture of that requester's operand; a response
    // transfers on a cycle where resp_valid and resp_ready are both high, and
    // resp_id/resp_root/resp_err stay stable while resp_valid is high and resp_ready low.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [1:0] ptr;
    logic [7:0] timer;
    logic [7:0] op_q;
    logic [1:0] id_q;
    logic [3:0] root_q;
    logic       err_q;

    logic       win_found;
    logic [1:0] win_id;
    logic [1:0] idx;
    logic       timed_out;

    // Round-robin pick: ptr has top priority, then ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign timed_out = (timer == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt     = '0;
        case (state)
            S_IDLE: begin
                if (win_found && !rst) begin
                    gnt     = NREQ'(1) << win_id;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (eng_done || timed_out) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath registers; eng_done in the timeout cycle wins over the abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            timer  <= '0;
            op_q   <= '0;
            id_q   <= '0;
            root_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        op_q <= req_operand[{win_id, 3'b000} +: 8];
                        id_q <= win_id;
                    end
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    if (timer != 8'hFF) begin
                        timer <= timer + 8'd1;
                    end
                    if (eng_done) begin
                        root_q <= eng_root;
                        err_q  <= 1'b0;
                    end else if (timed_out) begin
                        root_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        ptr <= id_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_start   = (state == S_ISSUE);
    assign eng_operand = op_q;
    assign resp_valid  = (state == S_RESP);
    assign resp_id     = id_q;
    assign resp_root   = root_q;
    assign resp_err    = err_q;
    assign busy        = (state != S_IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed bench for sqrt_sched: the bench plays the square-root engine and the response consumer.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_sqrt_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_operand;
    logic [3:0]  gnt;
    logic        eng_start;
    logic [7:0]  eng_operand;
    logic        eng_done;
    logic [3:0]  eng_root;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [3:0]  resp_root;
    logic        resp_err;
    logic        busy;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    sqrt_sched #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_operand (req_operand),
        .gnt         (gnt),
        .eng_start   (eng_start),
        .eng_operand (eng_operand),
        .eng_done    (eng_done),
        .eng_root    (eng_root),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_root   (resp_root),
        .resp_err    (resp_err),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant, then compare it.
    task automatic wait_gnt(input logic [3:0] exp);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != 4'd0) break;
        end
        check("gnt", 32'(gnt), 32'(exp));
    endtask

    // From the grant cycle: check the engine issue, answer after 'delay' WAIT cycles, check the response.
    task automatic finish_txn(input logic [3:0] clr, input logic [7:0] op, input int delay,
                              input logic [3:0] root, input logic [1:0] id);
        tick();
        req = req & ~clr;
        @(negedge clk);
        check("eng_start", 32'(eng_start), 32'd1);
        check("eng_operand", 32'(eng_operand), 32'(op));
        check("gnt_issue", 32'(gnt), 32'd0);
        repeat (delay) tick();
        eng_done = 1'b1;
        eng_root = root;
        @(negedge clk);
        check("resp_valid_wait", 32'(resp_valid), 32'd0);
        tick();
        eng_done = 1'b0;
        eng_root = 4'd0;
        @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_id", 32'(resp_id), 32'(id));
        check("resp_root", 32'(resp_root), 32'(root));
        check("resp_err", 32'(resp_err), 32'd0);
        check("gnt_resp", 32'(gnt), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        check({tag, "_eng_operand"}, 32'(eng_operand), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        check({tag, "_resp_root"}, 32'(resp_root), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    logic [3:0] fair_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] fair_op   [5] = '{8'd0, 8'd1, 8'd4, 8'd255, 8'd0};
    logic [3:0] fair_root [5] = '{4'd0, 4'd1, 4'd2, 4'd15, 4'd0};
    logic [1:0] fair_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst         = 1'b1;
        req         = 4'b1111;
        req_operand = 32'h0;
        eng_done    = 1'b0;
        eng_root    = 4'd0;
        resp_ready  = 1'b1;

        // Reset values while requests are pending
        #3;
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        req = 4'b0000;

        // Fairness: all four requesting, pointer wraps 3 -> 0
        req         = 4'b1111;
        req_operand = {8'd255, 8'd4, 8'd1, 8'd0};
        for (int t = 0; t < 5; t++) begin
            wait_gnt(fair_gnt[t]);
            finish_txn(4'b0000, fair_op[t], 2, fair_root[t], fair_id[t]);
        end
        tick();
        req = 4'b0000;

        // Single request, engine answers 5 cycles after start
        req_operand = {8'd0, 8'd0, 8'd0, 8'd144};
        req         = 4'b0001;
        wait_gnt(4'b0001);
        finish_txn(4'b0001, 8'd144, 5, 4'd12, 2'd0);
        tick();

        // Backpressure: response held 10 cycles while another request waits
        resp_ready  = 1'b0;
        req_operand = {8'd0, 8'd49, 8'd25, 8'd0};
        req         = 4'b0100;
        wait_gnt(4'b0100);
        finish_txn(4'b0100, 8'd49, 3, 4'd7, 2'd2);
        req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_id", 32'(resp_id), 32'd2);
            check("bp_resp_root", 32'(resp_root), 32'd7);
            check("bp_resp_err", 32'(resp_err), 32'd0);
            check("bp_gnt", 32'(gnt), 32'd0);
            check("bp_eng_start", 32'(eng_start), 32'd0);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_valid", 32'(resp_valid), 32'd1);
        tick();
        @(negedge clk);
        check("gnt_after_bp", 32'(gnt), 32'b0010);
        finish_txn(4'b0010, 8'd25, 2, 4'd5, 2'd1);
        tick();

        // Timeout: engine silent, abort 16 cycles after WAIT entry
        resp_ready  = 1'b0;
        req_operand = {8'd0, 8'd0, 8'd0, 8'd200};
        req         = 4'b0001;
        wait_gnt(4'b0001);
        tick();
        req = 4'b0000;
        @(negedge clk);
        check("to_eng_start", 32'(eng_start), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            @(negedge clk);
            check("to_resp_valid_early", 32'(resp_valid), 32'd0);
        end
        tick();
        @(negedge clk);
        check("to_resp_valid", 32'(resp_valid), 32'd1);
        check("to_resp_err", 32'(resp_err), 32'd1);
        check("to_resp_root", 32'(resp_root), 32'd0);
        check("to_resp_id", 32'(resp_id), 32'd0);
        tick();
        eng_done = 1'b1;
        eng_root = 4'd7;
        tick();
        eng_done = 1'b0;
        eng_root = 4'd0;
        @(negedge clk);
        check("late_done_root", 32'(resp_root), 32'd0);
        check("late_done_err", 32'(resp_err), 32'd1);
        check("late_done_valid", 32'(resp_valid), 32'd1);
        tick();
        resp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("to_busy_after", 32'(busy), 32'd0);
        tick();
        eng_done = 1'b1;
        eng_root = 4'd3;
        tick();
        eng_done = 1'b0;
        eng_root = 4'd0;
        @(negedge clk);
        check("idle_done_busy", 32'(busy), 32'd0);
        check("idle_done_start", 32'(eng_start), 32'd0);

        // Done arriving in the timeout cycle wins
        tick();
        req_operand = {8'd0, 8'd0, 8'd0, 8'd81};
        req         = 4'b0001;
        wait_gnt(4'b0001);
        finish_txn(4'b0001, 8'd81, 16, 4'd9, 2'd0);
        tick();

        // Asynchronous reset in WAIT, asserted mid-cycle
        req_operand = {8'd100, 8'd0, 8'd0, 8'd0};
        req         = 4'b1000;
        wait_gnt(4'b1000);
        tick();
        req = 4'b0000;
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        req = 4'b1111;
        #1;
        check_reset_outputs("async_rst");
        tick();
        rst      = 1'b0;
        req      = 4'b0000;
        eng_done = 1'b1;
        eng_root = 4'd5;
        @(negedge clk);
        check("post_rst_done_busy", 32'(busy), 32'd0);
        check("post_rst_done_valid", 32'(resp_valid), 32'd0);
        tick();
        eng_done    = 1'b0;
        eng_root    = 4'd0;
        req_operand = {8'd0, 8'd100, 8'd0, 8'd0};
        req         = 4'b0100;
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt), 32'b0100);
        finish_txn(4'b0100, 8'd100, 3, 4'd10, 2'd2);
        tick();
        @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
